// File: rtl/fp_normalizer.sv
// Post-add normalization stage for the half-precision FP adder: moves the leading one
// of the raw mantissa sum to the hidden-bit position and packs {sign, exp, fraction}.
module fp_normalizer #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic [MANT_W+1:0]        in_mant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MANT_W:0]    out_result,
  output logic                     zero_flag,
  output logic                     overflow_flag,
  output logic                     underflow_flag
);

  localparam logic [EXP_W-1:0] EXP_MAX    = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, LSHIFT, DONE} state_t;

  state_t              state_q;
  logic                sign_q;
  logic [EXP_W-1:0]    exp_q;
  logic [MANT_W+1:0]   mant_q;

  logic [MANT_W+1:0]   mantShl_d;
  logic [EXP_W-1:0]    expInc_d;
  logic [EXP_W-1:0]    expDec_d;
  logic [EXP_W+MANT_W:0] signedZero_d;
  logic [EXP_W+MANT_W:0] signedInf_d;

  assign mantShl_d    = {mant_q[MANT_W:0], 1'b0};
  assign expInc_d     = exp_q + EXP_ONE;
  assign expDec_d     = exp_q - EXP_ONE;
  assign signedZero_d = {sign_q, {(EXP_W+MANT_W){1'b0}}};
  assign signedInf_d  = {sign_q, EXP_MAX, {MANT_W{1'b0}}};

  assign in_ready = (state_q == IDLE) && !reset;

  // CHECK classifies the sum once; LSHIFT then walks the leading one up a bit per cycle,
  // flushing to zero rather than producing subnormals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      zero_flag      <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= in_exp;
            mant_q  <= in_mant;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (mant_q == '0) begin
            out_result <= signedZero_d;
            zero_flag  <= 1'b1;
            out_valid  <= 1'b1;
            state_q    <= DONE;
          end else if (exp_q == EXP_MAX) begin
            out_result    <= signedInf_d;
            overflow_flag <= 1'b1;
            out_valid     <= 1'b1;
            state_q       <= DONE;
          end else if (mant_q[MANT_W+1]) begin
            if (exp_q >= EXP_MAX_M1) begin
              out_result    <= signedInf_d;
              overflow_flag <= 1'b1;
            end else begin
              exp_q      <= expInc_d;
              mant_q     <= {1'b0, mant_q[MANT_W+1:1]};
              out_result <= {sign_q, expInc_d, mant_q[MANT_W:1]};
            end
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (mant_q[MANT_W]) begin
            if (exp_q == '0) begin
              out_result     <= signedZero_d;
              underflow_flag <= 1'b1;
            end else begin
              out_result <= {sign_q, exp_q, mant_q[MANT_W-1:0]};
            end
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            state_q <= LSHIFT;
          end
        end
        LSHIFT: begin
          if (exp_q <= EXP_ONE) begin
            out_result     <= signedZero_d;
            underflow_flag <= 1'b1;
            out_valid      <= 1'b1;
            state_q        <= DONE;
          end else begin
            mant_q <= mantShl_d;
            exp_q  <= expDec_d;
            if (mantShl_d[MANT_W]) begin
              out_result <= {sign_q, expDec_d, mantShl_d[MANT_W-1:0]};
              out_valid  <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            zero_flag      <= 1'b0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases plus randomized operands
// compared against an arithmetic reference model of the normalization rules.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        zero_flag;
  logic        overflow_flag;
  logic        underflow_flag;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  fp_normalizer #(.MANT_W(10), .EXP_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .underflow_flag(underflow_flag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: value-level rules; flags are {zero, overflow, underflow}, lat counts
  // clock edges from the accepting edge to the first edge after which out_valid is high.
  function automatic void refModel(input logic s, input int e, input int m,
                                   output logic [15:0] res, output logic [2:0] flags, output int lat);
    int lz;
    flags = 3'b000;
    lat   = 1;
    res   = {s, 15'd0};
    if (m == 0) begin
      flags = 3'b100;
    end else if (e == 31) begin
      res = {s, 5'd31, 10'd0}; flags = 3'b010;
    end else if (m >= 2048) begin
      if (e >= 30) begin
        res = {s, 5'd31, 10'd0}; flags = 3'b010;
      end else begin
        res = {s, 5'(e + 1), 10'((m / 2) % 1024)};
      end
    end else if (m >= 1024) begin
      if (e == 0) flags = 3'b001;
      else res = {s, 5'(e), 10'(m % 1024)};
    end else begin
      lz = 0;
      while ((m * (2 ** lz)) < 1024) lz++;
      if (e > lz) begin
        res = {s, 5'(e - lz), 10'((m * (2 ** lz)) % 1024)};
        lat = 1 + lz;
      end else begin
        flags = 3'b001;
        lat = 2 + ((e >= 2) ? e - 1 : 0);
      end
    end
  endfunction

  task automatic applyStimulus(input logic s, input int e, input int m, input int holdCycles);
    logic [15:0] expRes;
    logic [2:0]  expFlags;
    int          expLat;
    int          waitCnt;
    int          lat;
    refModel(s, e, m, expRes, expFlags, expLat);
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("accept_ready", in_ready, 1);
    in_sign  = s;
    in_exp   = 5'(e);
    in_mant  = 12'(m);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("busy_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("result", out_result, expRes);
    checkOutput("flags", {zero_flag, overflow_flag, underflow_flag}, expFlags);
    repeat (holdCycles) begin
      @(posedge clk); #1;
    end
    if (holdCycles > 0) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_result", out_result, expRes);
      checkOutput("hold_flags", {zero_flag, overflow_flag, underflow_flag}, expFlags);
      checkOutput("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("drain_valid", out_valid, 0);
    checkOutput("drain_flags", {zero_flag, overflow_flag, underflow_flag}, 0);
    checkOutput("drain_ready", in_ready, 1);
  endtask

  initial begin
    int sawValid;
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", in_ready, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_result", out_result, 0);
    checkOutput("reset_flags", {zero_flag, overflow_flag, underflow_flag}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, 15, 12'b01_1000000000, 0);
    applyStimulus(1'b0, 15, 12'b10_0000000001, 0);
    applyStimulus(1'b0, 20, 12'b00_0000100000, 0);
    applyStimulus(1'b1, 5,  12'b00_0000000001, 0);
    applyStimulus(1'b0, 30, 12'b10_0000000000, 0);
    applyStimulus(1'b0, 31, 12'b00_0000010011, 0);
    applyStimulus(1'b1, 0,  12'b00_0000000000, 5);
    applyStimulus(1'b0, 0,  12'b01_0000000011, 1);
    applyStimulus(1'b1, 11, 12'b00_0000000001, 2);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 4095) >> $urandom_range(0, 12)),
                    int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a long left-shift sequence must abandon the operand.
    in_sign = 1'b0; in_exp = 5'd20; in_mant = 12'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("postreset_ready", in_ready, 1);
    sawValid = 0;
    repeat (15) begin
      if (out_valid) sawValid = 1;
      @(posedge clk); #1;
    end
    checkOutput("postreset_no_valid", sawValid, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
